// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains a FIFO read port into ready/valid bursts with a last marker
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_DEPTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    parameter int MAX_BURST  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  enable_i,
    input  logic                  fifo_full_i,
    input  logic                  fifo_empty_i,
    input  logic [ADDR_DEPTH-1:0] fifo_usage_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o
);

    localparam int AVAIL_W = ADDR_DEPTH + 1;
    localparam int BEAT_W  = $clog2(MAX_BURST + 1);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    localparam logic [AVAIL_W-1:0] DEPTH_C     = AVAIL_W'(FIFO_DEPTH);
    localparam logic [AVAIL_W-1:0] BURST_C     = AVAIL_W'(MAX_BURST);
    localparam logic [BEAT_W-1:0]  MAX_BEATS_C = BEAT_W'(MAX_BURST);
    localparam logic [TIMER_W-1:0] TIMEOUT_C   = TIMER_W'(TIMEOUT);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_e;

    state_e                state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [BEAT_W-1:0]     beats_left_q, beats_left_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

    logic [AVAIL_W-1:0]    avail;
    logic                  slot_free;
    logic                  pop;
    logic                  start;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            beats_left_q <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            beats_left_q <= beats_left_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
        end
    end

    // The FIFO reports usage 0 when full, so the full flag supplies the missing top count.
    always_comb begin
        avail     = fifo_full_i ? DEPTH_C : {1'b0, fifo_usage_i};
        slot_free = ~m_valid_q | m_ready_i;
        pop       = (state_q == ST_BURST) & (beats_left_q != '0) & slot_free
                    & ~fifo_empty_i & ~flush_i;
        start     = enable_i & ((avail >= BURST_C) | ((avail != '0) & (timer_q == TIMEOUT_C)));

        state_d      = state_q;
        timer_d      = timer_q;
        beats_left_d = beats_left_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_data_d     = m_data_q;

        if (flush_i) begin
            state_d      = ST_IDLE;
            timer_d      = '0;
            beats_left_d = '0;
            m_valid_d    = 1'b0;
            m_last_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (avail == '0) begin
                        timer_d = '0;
                    end else if ((avail < BURST_C) && (timer_q != TIMEOUT_C)) begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                    if (start) begin
                        beats_left_d = (avail >= BURST_C) ? MAX_BEATS_C : BEAT_W'(avail);
                        timer_d      = '0;
                        state_d      = ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (pop) begin
                        m_data_d     = fifo_data_i;
                        m_valid_d    = 1'b1;
                        m_last_d     = (beats_left_q == BEAT_W'(1));
                        beats_left_d = beats_left_q - BEAT_W'(1);
                    end else if (slot_free) begin
                        m_valid_d = 1'b0;
                    end
                    if (m_valid_q && m_ready_i && m_last_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_pop_o = pop & rst_ni;
        m_valid_o  = m_valid_q;
        m_data_o   = m_data_q;
        m_last_o   = m_last_q;
        busy_o     = (state_q == ST_BURST);
    end

    // A stalled beat must not change until the consumer takes it (a flush drops it instead).
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (m_valid_o && !m_ready_i && !flush_i) |=> ($stable(m_data_o) && $stable(m_last_o)));

    assert property (@(posedge clk_i) !(fifo_pop_o && fifo_empty_i));

    assert property (@(posedge clk_i) disable iff (!rst_ni) beats_left_q <= MAX_BEATS_C);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - scoreboard bench for fifo_burst_reader with a behavioural FIFO
module tb_fifo_burst_reader;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AD    = 3;
    localparam int MB    = 4;
    localparam int TO    = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          enable_i = 1'b1;
    logic          fifo_full_i = 1'b0;
    logic          fifo_empty_i = 1'b1;
    logic [AD-1:0] fifo_usage_i = '0;
    logic [DW-1:0] fifo_data_i = '0;
    logic          fifo_pop_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b1;
    logic [DW-1:0] m_data_o;
    logic          m_last_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    fifo_burst_reader #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .MAX_BURST (MB),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .enable_i    (enable_i),
        .fifo_full_i (fifo_full_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_usage_i(fifo_usage_i),
        .fifo_data_i (fifo_data_i),
        .fifo_pop_o  (fifo_pop_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o),
        .busy_o      (busy_o)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] fifo_m[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            pop_cnt = 0;
    int            hs_cnt = 0;
    int            last_cnt = 0;
    int            burst_beats = 0;
    logic          pop_pending = 1'b0;

    // FIFO model drives its read side after each negedge; beats are scored just before each posedge.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk_i);
            #1;
            fifo_full_i  = (fifo_m.size() == DEPTH);
            fifo_empty_i = (fifo_m.size() == 0);
            fifo_usage_i = AD'(fifo_m.size());
            fifo_data_i  = (fifo_m.size() == 0) ? '0 : fifo_m[0];
            #3;
            pop_pending = fifo_pop_o;
            if (!rst_ni || flush_i) burst_beats = 0;
            if (m_valid_o && m_ready_i) begin
                hs_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got data=%0h last=%0b, scoreboard empty", m_data_o, m_last_o);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data_o !== e.data || m_last_o !== e.last) begin
                        n_fail++;
                        $display("FAIL beat: got data=%0h last=%0b expected data=%0h last=%0b",
                                 m_data_o, m_last_o, e.data, e.last);
                    end
                end
                burst_beats++;
                n_cmp++;
                if (burst_beats > MB) begin
                    n_fail++;
                    $display("FAIL burst_len: got %0d beats without last, limit %0d", burst_beats, MB);
                end
                if (m_last_o) begin
                    last_cnt++;
                    burst_beats = 0;
                end
            end
            @(posedge clk_i);
            #1;
            if (pop_pending) begin
                n_cmp++;
                if (fifo_m.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_on_empty: got pop=1 expected no pop from empty FIFO");
                end else begin
                    void'(fifo_m.pop_front());
                    pop_cnt++;
                end
            end
        end
    end

    task automatic push_word(input logic [DW-1:0] d, input logic expect_it, input logic last);
        beat_t e;
        fifo_m.push_back(d);
        if (expect_it) begin
            e.data = d;
            e.last = last;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            rst_ni = 1'b0;
            #4;
            if (i == 2) begin
                n_cmp += 5;
                if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", m_valid_o); end
                if (m_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", m_data_o); end
                if (m_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b expected 0", m_last_o); end
                if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
                if (fifo_pop_o !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %0b expected 0", fifo_pop_o); end
            end
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_full_burst();
        int   p0;
        int   first;
        int   lastp;
        logic busy_s[12];
        p0 = pop_cnt;
        first = -1;
        lastp = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (i == 0) for (int k = 0; k < 4; k++) push_word(32'hA0 + k, 1'b1, k == 3);
            #4;
            busy_s[i] = busy_o;
            if (fifo_pop_o) begin
                if (first < 0) first = i;
                lastp = i;
            end
        end
        n_cmp += 6;
        if (pop_cnt - p0 !== 4) begin n_fail++; $display("FAIL full_pops: got %0d expected 4", pop_cnt - p0); end
        if (first !== 1) begin n_fail++; $display("FAIL full_first_pop: got cycle %0d expected 1", first); end
        if (lastp !== 4) begin n_fail++; $display("FAIL full_last_pop: got cycle %0d expected 4", lastp); end
        if (busy_s[5] !== 1'b1) begin n_fail++; $display("FAIL full_busy_at_last: got %0b expected 1", busy_s[5]); end
        if (busy_s[6] !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %0b expected 0", busy_s[6]); end
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL full_leftover: got %0d beats pending expected 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int first;
        for (int r = 0; r < 2; r++) begin
            first = -1;
            for (int i = 0; i < 24; i++) begin
                @(negedge clk_i);
                if (i == 0) push_word(32'hB0 + r, 1'b1, 1'b1);
                #4;
                if (fifo_pop_o && first < 0) first = i;
            end
            n_cmp += 2;
            if (first !== TO + 1) begin n_fail++; $display("FAIL timeout_first_pop: got cycle %0d expected %0d", first, TO + 1); end
            if (exp_q.size() !== 0) begin n_fail++; $display("FAIL timeout_leftover: got %0d expected 0", exp_q.size()); end
        end
    endtask

    task automatic test_full_wrap();
        int p0;
        int h0;
        int l0;
        p0 = pop_cnt;
        h0 = hs_cnt;
        l0 = last_cnt;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk_i);
            if (i == 0) for (int k = 0; k < 8; k++) push_word(32'hC0 + k, 1'b1, (k == 3) || (k == 7));
            #4;
        end
        n_cmp += 4;
        if (pop_cnt - p0 !== 8) begin n_fail++; $display("FAIL wrap_pops: got %0d expected 8", pop_cnt - p0); end
        if (hs_cnt - h0 !== 8) begin n_fail++; $display("FAIL wrap_beats: got %0d expected 8", hs_cnt - h0); end
        if (last_cnt - l0 !== 2) begin n_fail++; $display("FAIL wrap_lasts: got %0d expected 2", last_cnt - l0); end
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL wrap_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int h0;
        h0 = hs_cnt;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_i);
            if (i == 0) for (int k = 0; k < 4; k++) push_word(32'hD0 + k, 1'b1, k == 3);
            m_ready_i = !(i >= 4 && i <= 6);
            #4;
            if (i >= 4 && i <= 6) begin
                n_cmp += 4;
                if (m_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %0b expected 1", m_valid_o); end
                if (m_data_o !== 32'hD2) begin n_fail++; $display("FAIL stall_data: got %0h expected d2", m_data_o); end
                if (m_last_o !== 1'b0) begin n_fail++; $display("FAIL stall_last: got %0b expected 0", m_last_o); end
                if (fifo_pop_o !== 1'b0) begin n_fail++; $display("FAIL stall_pop: got %0b expected 0", fifo_pop_o); end
            end
        end
        m_ready_i = 1'b1;
        n_cmp += 2;
        if (hs_cnt - h0 !== 4) begin n_fail++; $display("FAIL stall_beats: got %0d expected 4", hs_cnt - h0); end
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stall_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 36; i++) begin
            @(negedge clk_i);
            if (i == 0) begin
                push_word(32'hE0, 1'b1, 1'b0);
                push_word(32'hE1, 1'b1, 1'b0);
                push_word(32'hE2, 1'b0, 1'b0);
                push_word(32'hE3, 1'b1, 1'b0);
                push_word(32'hE4, 1'b1, 1'b0);
                push_word(32'hE5, 1'b1, 1'b1);
            end
            flush_i   = (i == 4);
            m_ready_i = (i != 4);
            #4;
            if (i == 4) begin
                n_cmp++;
                if (fifo_pop_o !== 1'b0) begin n_fail++; $display("FAIL flush_pop: got %0b expected 0", fifo_pop_o); end
            end
            if (i == 5) begin
                n_cmp += 2;
                if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b expected 0", m_valid_o); end
                if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %0b expected 0", busy_o); end
            end
        end
        n_cmp += 2;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL flush_leftover: got %0d expected 0", exp_q.size()); end
        if (fifo_m.size() !== 0) begin n_fail++; $display("FAIL flush_fifo: got %0d words expected 0", fifo_m.size()); end
    endtask

    task automatic test_enable_reset();
        int   p0;
        logic busy_seen;
        p0 = pop_cnt;
        busy_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            enable_i = 1'b0;
            if (i == 0) for (int k = 0; k < 8; k++) push_word(32'hF0 + k, k != 2, (k == 6) || (k == 7));
            #4;
            if (busy_o) busy_seen = 1'b1;
        end
        n_cmp += 2;
        if (pop_cnt - p0 !== 0) begin n_fail++; $display("FAIL disabled_pops: got %0d expected 0", pop_cnt - p0); end
        if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL disabled_busy: got %0b expected 0", busy_seen); end
        for (int i = 0; i < 44; i++) begin
            @(negedge clk_i);
            enable_i  = 1'b1;
            rst_ni    = !(i == 4 || i == 5);
            m_ready_i = !(i == 4 || i == 5);
            #4;
            if (i == 4) begin
                n_cmp++;
                if (fifo_pop_o !== 1'b0) begin n_fail++; $display("FAIL rst_pop: got %0b expected 0", fifo_pop_o); end
            end
            if (i == 5) begin
                n_cmp += 4;
                if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", m_valid_o); end
                if (m_data_o !== '0) begin n_fail++; $display("FAIL rst_data: got %0h expected 0", m_data_o); end
                if (m_last_o !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %0b expected 0", m_last_o); end
                if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy_o); end
            end
        end
        n_cmp += 2;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rst_leftover: got %0d expected 0", exp_q.size()); end
        if (fifo_m.size() !== 0) begin n_fail++; $display("FAIL rst_fifo: got %0d words expected 0", fifo_m.size()); end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_timeout();
        test_full_wrap();
        test_backpressure();
        test_flush();
        test_enable_reset();
        repeat (4) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Drains a push/pop FIFO through its read side: full, usage, empty, data and pop.
- Emits the drained words as ready/valid bursts of up to MAX_BURST beats, with a last marker on the final beat.
- Starts a full burst as soon as MAX_BURST words are available. Starts a partial burst after TIMEOUT cycles of waiting with fewer words.
- Sits between an RDMA ingress FIFO and a burst-oriented consumer such as a DMA write engine.

Parameters:
- DATA_WIDTH, 32: word width.
- FIFO_DEPTH, 8: depth of the attached FIFO; must be >= 1.
- ADDR_DEPTH, (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1: width of the FIFO usage input. Derived; do not override.
- MAX_BURST, 4: maximum beats per burst; 1 <= MAX_BURST <= FIFO_DEPTH.
- TIMEOUT, 16: idle cycles before a partial burst is forced; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  synchronous abort of the current burst
- enable_i  in  1  allow new bursts to start
- fifo_full_i  in  1  FIFO full flag
- fifo_empty_i  in  1  FIFO empty flag
- fifo_usage_i  in  ADDR_DEPTH  FIFO fill count; reads 0 when the FIFO is full
- fifo_data_i  in  DATA_WIDTH  FIFO head word
- fifo_pop_o  out  1  pop FIFO head
- m_valid_o  out  1  output beat valid
- m_ready_i  in  1  consumer ready
- m_data_o  out  DATA_WIDTH  output beat data
- m_last_o  out  1  final beat of the burst
- busy_o  out  1  burst in progress (state BURST)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset values: state IDLE, m_valid_o=0, m_data_o=0, m_last_o=0, busy_o=0, timer=0, beats_left=0. fifo_pop_o=0 while rst_ni=0.
- Available count: avail = fifo_full_i ? FIFO_DEPTH : zero-extended fifo_usage_i, width ADDR_DEPTH+1. This resolves usage wrapping to 0 at full.
- Output slot: slot_free = ~m_valid_o | m_ready_i.
- Handshake: a beat transfers when m_valid_o & m_ready_i. While m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o hold stable.
- IDLE state:
  - timer clears to 0 when avail==0.
  - timer increments, saturating at TIMEOUT, when 0 < avail < MAX_BURST.
  - Burst starts when enable_i & (avail >= MAX_BURST | (avail > 0 & timer == TIMEOUT)).
  - On start: beats_left <= min(avail, MAX_BURST), timer <= 0, state <= BURST.
  - No pops in IDLE.
- BURST state:
  - fifo_pop_o = beats_left != 0 & slot_free & ~fifo_empty_i & ~flush_i (combinational).
  - On pop: m_data_o <= fifo_data_i, m_valid_o <= 1, m_last_o <= (beats_left == 1), beats_left decrements.
  - If slot_free and no pop: m_valid_o <= 0.
  - Pops may occur every cycle, so a burst can stream back-to-back with m_ready_i held at 1.
  - BURST -> IDLE on the handshake of the beat with m_last_o=1.
  - The FIFO is only drained by this block, so the latched length is always satisfiable. fifo_empty_i=1 with beats_left != 0 is a protocol error: the block stalls and does not pop.
- Latency:
  - Start condition true in cycle N: first pop in N+1, m_valid_o=1 in N+2.
  - Next burst may be decided in the cycle after the return to IDLE.
- enable_i deasserted: blocks new starts only. A burst in progress completes.
- flush_i (synchronous, higher priority than all updates except reset): state <= IDLE, m_valid_o <= 0, m_last_o <= 0, beats_left <= 0, timer <= 0, no pop that cycle. The beat held in m_data_o is dropped. Words still in the FIFO are not popped and are re-evaluated in IDLE.
- Reset mid-burst: same effect as flush, plus m_data_o <= 0.
- fifo_pop_o is never asserted while fifo_empty_i=1.
- Assertions:
  - Stability: m_valid_o & ~m_ready_i |-> next cycle same m_data_o and m_last_o.
  - Every burst is at most MAX_BURST beats and ends with m_last_o.

Test Plan:
- Full burst (defaults): FIFO holds A0..A3 (usage=4), m_ready_i=1 → pops on 4 consecutive cycles; beats A0..A3 back-to-back; m_last_o=1 only on A3; busy_o falls after the A3 handshake.
- Partial timeout: 1 word B0, TIMEOUT=16 → no pop for 16 cycles, then a single beat B0 with m_last_o=1; timer restarts from 0.
- Full wrap: FIFO full (full=1, usage=0) → avail=8; two bursts of 4 beats, each with m_last_o on beat 4; 8 pops total, 0 extra.
- Backpressure: m_ready_i=0 for 3 cycles after beat 2 → m_data_o and m_last_o stable, fifo_pop_o=0 during the stall, all 4 beats delivered in order with no loss.
- Flush mid-burst: flush_i pulsed after 2 handshakes of a 4-beat burst → next cycle m_valid_o=0, busy_o=0, no pop in the flush cycle; the remaining FIFO words start a new burst per the IDLE rules.
- Enable and reset: enable_i=0 with 8 words → no pops. Reset asserted mid-burst → all outputs 0 the next cycle. After reset release with enable_i=1 → the burst restarts from the FIFO head.
